// File: rtl/code_lock_if.sv
// Keypad-side and status-side signals of the code lock, grouped as one bundle.
// master drives key presses; slave is the lock controller.
interface code_lock_if #(
  parameter int DIGIT_W = 4,
  parameter int CNT_W   = 3
);
  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               unlocked;
  logic               prog_mode;
  logic               lockout;
  logic               ok_pulse;
  logic               fail_pulse;
  logic [CNT_W-1:0]   digit_count;

  modport master (
    output digit_valid,
    output digit,
    input  unlocked,
    input  prog_mode,
    input  lockout,
    input  ok_pulse,
    input  fail_pulse,
    input  digit_count
  );

  modport slave (
    input  digit_valid,
    input  digit,
    output unlocked,
    output prog_mode,
    output lockout,
    output ok_pulse,
    output fail_pulse,
    output digit_count
  );
endinterface

// File: rtl/code_lock_ctrl.sv
// Parametrised keypad code lock: user/programming codes, timed unlock.
// Failed-attempt counter and timed lockout only when LOCKOUT_EN is defined.
module code_lock_ctrl #(
  parameter int CODE_LEN = 6,
  parameter int DIGIT_W  = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] UC_INIT = 24'h123456,
  parameter logic [CODE_LEN*DIGIT_W-1:0] PC_CODE = 24'h666666,
  parameter logic [DIGIT_W-1:0] CLR_KEY = 4'hF,
  parameter int UNLOCK_CYCLES  = 12_000_000,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 120_000_000
) (
  input logic       hwclk,
  input logic       reset,
  code_lock_if.slave bus
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int UT_W   = $clog2(UNLOCK_CYCLES + 1);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CODE_LEN);
  localparam logic [UT_W-1:0]  UT_C  = UT_W'(UNLOCK_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_UNLOCKED,
    S_PROGRAM,
    S_PROG_STORE,
    S_LOCKOUT
  } state_t;

  state_t            state;
  logic [CODE_W-1:0] sr;
  logic [CODE_W-1:0] uc;
  logic [CNT_W-1:0]  cnt;
  logic [UT_W-1:0]   unl_tmr;
  logic              unl_r;
  logic              prog_r;
  logic              ok_r;
  logic              fail_r;

  logic [CODE_W-1:0] shifted;
  logic              is_clr;
  logic              pc_hit;
  logic              uc_hit;

  // First digit keyed ends up in the most-significant digit slot.
  assign shifted = (sr << DIGIT_W) | CODE_W'(bus.digit);
  assign is_clr  = (bus.digit == CLR_KEY);
  assign pc_hit  = (sr == PC_CODE);
  assign uc_hit  = (sr == uc);

`ifdef LOCKOUT_EN
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int LT_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [FW-1:0]   MAX_C = FW'(MAX_FAIL);
  localparam logic [LT_W-1:0] LT_C  = LT_W'(LOCKOUT_CYCLES);

  logic [FW-1:0]   fail_cnt;
  logic [FW-1:0]   fail_inc;
  logic [LT_W-1:0] lock_tmr;
  logic            lock_r;

  assign fail_inc = (fail_cnt == MAX_C) ? MAX_C : fail_cnt + FW'(1);
  assign bus.lockout = lock_r;
`else
  logic unused_cfg;

  assign unused_cfg  = ^{32'(MAX_FAIL), 32'(LOCKOUT_CYCLES)};
  assign bus.lockout = 1'b0;
`endif

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      sr      <= '0;
      uc      <= UC_INIT;
      cnt     <= '0;
      unl_tmr <= '0;
      unl_r   <= 1'b0;
      prog_r  <= 1'b0;
      ok_r    <= 1'b0;
      fail_r  <= 1'b0;
`ifdef LOCKOUT_EN
      fail_cnt <= '0;
      lock_tmr <= '0;
      lock_r   <= 1'b0;
`endif
    end else begin
      ok_r   <= 1'b0;
      fail_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.digit_valid && !is_clr) begin
            sr    <= shifted;
            cnt   <= CNT_W'(1);
            state <= S_ENTRY;
          end
        end

        // Digit collection shared by code entry and UC programming.
        S_ENTRY, S_PROGRAM: begin
          if (cnt == LEN_C) begin
            cnt   <= '0;
            state <= (state == S_ENTRY) ? S_CHECK : S_PROG_STORE;
          end else if (bus.digit_valid) begin
            if (is_clr) begin
              sr     <= '0;
              cnt    <= '0;
              prog_r <= 1'b0;
              state  <= S_IDLE;
            end else begin
              sr  <= shifted;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        S_CHECK: begin
          if (pc_hit) begin
            prog_r <= 1'b1;
            state  <= S_PROGRAM;
          end else if (uc_hit) begin
            unl_r   <= 1'b1;
            ok_r    <= 1'b1;
            unl_tmr <= UT_C;
            state   <= S_UNLOCKED;
`ifdef LOCKOUT_EN
            fail_cnt <= '0;
`endif
          end else begin
            fail_r <= 1'b1;
`ifdef LOCKOUT_EN
            fail_cnt <= fail_inc;
            if (fail_inc == MAX_C) begin
              lock_r   <= 1'b1;
              lock_tmr <= LT_C;
              state    <= S_LOCKOUT;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end
        end

        // Any key press relocks; the key itself is dropped.
        S_UNLOCKED: begin
          if (bus.digit_valid || unl_tmr == UT_W'(1)) begin
            unl_r   <= 1'b0;
            unl_tmr <= '0;
            state   <= S_IDLE;
          end else begin
            unl_tmr <= unl_tmr - UT_W'(1);
          end
        end

        S_PROG_STORE: begin
          if (pc_hit) begin
            fail_r <= 1'b1;
          end else begin
            uc   <= sr;
            ok_r <= 1'b1;
          end
          prog_r <= 1'b0;
          state  <= S_IDLE;
        end

`ifdef LOCKOUT_EN
        S_LOCKOUT: begin
          if (lock_tmr == LT_W'(1)) begin
            lock_r   <= 1'b0;
            lock_tmr <= '0;
            fail_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            lock_tmr <= lock_tmr - LT_W'(1);
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.unlocked    = unl_r;
  assign bus.prog_mode   = prog_r;
  assign bus.ok_pulse    = ok_r;
  assign bus.fail_pulse  = fail_r;
  assign bus.digit_count = cnt;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: pulse events are queued by the
// stimulus and popped by an independent monitor.
module tb_code_lock_ctrl;

  localparam int DW = 4;
  localparam int CW = 3;

  logic hwclk = 1'b0;
  logic reset;

  always #5 hwclk = ~hwclk;

  code_lock_if #(.DIGIT_W(DW), .CNT_W(CW)) bus ();

  code_lock_ctrl #(
    .CODE_LEN(6),
    .DIGIT_W(DW),
    .UC_INIT(24'h123456),
    .PC_CODE(24'h666666),
    .CLR_KEY(4'hF),
    .UNLOCK_CYCLES(20),
    .MAX_FAIL(3),
    .LOCKOUT_CYCLES(50)
  ) dut (
    .hwclk(hwclk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic ok;
    logic fail;
    logic unl;
    logic prg;
    logic lck;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic exp_ev(input logic ok, input logic fail, input logic unl,
                        input logic prg, input logic lck);
    ev_t e;
    e = '{ok: ok, fail: fail, unl: unl, prg: prg, lck: lck};
    exp_q.push_back(e);
  endtask

  // Monitor: every ok/fail pulse must match the oldest queued event.
  initial begin
    ev_t got;
    ev_t e;
    forever begin
      @(posedge hwclk);
      #1;
      if (reset === 1'b0 && (bus.ok_pulse || bus.fail_pulse)) begin
        got = {bus.ok_pulse, bus.fail_pulse, bus.unlocked,
               bus.prog_mode, bus.lockout};
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'(got), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_event", 32'(got), 32'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge hwclk);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    @(negedge hwclk);
    bus.digit_valid = 1'b0;
  endtask

  task automatic key_code(input logic [23:0] c);
    for (int i = 5; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  function automatic logic pick(input int which);
    return (which == 0) ? bus.unlocked : bus.lockout;
  endfunction

  // Waits (bounded) for the output to rise, then counts high cycles.
  task automatic measure_high(input int which, input int want,
                              input string name);
    int n;
    bit seen;
    n    = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (pick(which)) seen = 1;
      else @(negedge hwclk);
    end
    chk({name, "_rise"}, 32'(seen), 32'd1);
    if (seen) begin
      while (pick(which) && n < 200) begin
        n++;
        @(negedge hwclk);
      end
      chk(name, n, want);
    end
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, bus.unlocked, bus.prog_mode, bus.lockout,
            bus.ok_pulse, bus.fail_pulse, bus.digit_count};
  endfunction

  initial begin
    bit up;
    reset           = 1'b1;
    bus.digit_valid = 1'b0;
    bus.digit       = '0;
    idle(2);
    chk("reset_state", outs(), 32'd0);
    reset = 1'b0;
    idle(2);

    // Correct user code
    exp_ev(1, 0, 1, 0, 0);
    key_code(24'h123456);
    measure_high(0, 20, "t1_unlock_len");
    idle(3);

    // New UC equal to PC is rejected
    key_code(24'h666666);
    idle(2);
    chk("t3_prog_mode", 32'(bus.prog_mode), 32'd1);
    exp_ev(0, 1, 0, 0, 0);
    key_code(24'h666666);
    idle(3);
    chk("t3_prog_drop", 32'(bus.prog_mode), 32'd0);
    exp_ev(1, 0, 1, 0, 0);
    key_code(24'h123456);
    measure_high(0, 20, "t3_uc_kept");
    idle(3);

    // Reprogram UC to 987654
    key_code(24'h666666);
    idle(2);
    chk("t2_prog_mode", 32'(bus.prog_mode), 32'd1);
    chk("t2_locked", 32'(bus.unlocked), 32'd0);
    exp_ev(1, 0, 0, 0, 0);
    key_code(24'h987654);
    idle(3);
    chk("t2_prog_drop", 32'(bus.prog_mode), 32'd0);
    exp_ev(0, 1, 0, 0, 0);
    key_code(24'h123456);
    idle(3);
    chk("t2_old_uc_locked", 32'(bus.unlocked), 32'd0);
    exp_ev(1, 0, 1, 0, 0);
    key_code(24'h987654);
    measure_high(0, 20, "t2_new_uc");
    idle(3);

    // Asynchronous reset mid-programming restores UC_INIT
    key_code(24'h666666);
    idle(2);
    press(4'h9);
    press(4'h8);
    press(4'h7);
    chk("t6_count3", 32'(bus.digit_count), 32'd3);
    chk("t6_prog", 32'(bus.prog_mode), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_clear", outs(), 32'd0);
    @(negedge hwclk);
    reset = 1'b0;
    idle(2);
    exp_ev(0, 1, 0, 0, 0);
    key_code(24'h987654);
    idle(3);
    exp_ev(1, 0, 1, 0, 0);
    key_code(24'h123456);
    measure_high(0, 20, "t6_uc_init");
    idle(3);

    // Three wrong codes
    for (int k = 0; k < 3; k++) begin
`ifdef LOCKOUT_EN
      exp_ev(0, 1, 0, 0, (k == 2));
`else
      exp_ev(0, 1, 0, 0, 0);
`endif
      key_code(24'h111111);
      if (k < 2) idle(3);
    end
`ifdef LOCKOUT_EN
    fork
      measure_high(1, 50, "t4_lockout_len");
      begin
        idle(3);
        key_code(24'h123456);
        chk("t4_lock_count", 32'(bus.digit_count), 32'd0);
        chk("t4_lock_unl", 32'(bus.unlocked), 32'd0);
      end
    join
    idle(2);
`else
    idle(3);
    chk("t4_no_lockout", 32'(bus.lockout), 32'd0);
`endif
    exp_ev(1, 0, 1, 0, 0);
    key_code(24'h123456);
    measure_high(0, 20, "t4_after_lock");
    idle(3);

    // Clear mid-entry, then relock by key press
    press(4'h1);
    press(4'h2);
    press(4'h3);
    chk("t5_count3", 32'(bus.digit_count), 32'd3);
    press(4'hF);
    chk("t5_clr_count", 32'(bus.digit_count), 32'd0);
    exp_ev(1, 0, 1, 0, 0);
    key_code(24'h123456);
    up = 0;
    for (int i = 0; i < 10 && !up; i++) begin
      if (bus.unlocked) up = 1;
      else @(negedge hwclk);
    end
    chk("t5_unlocked", 32'(bus.unlocked), 32'd1);
    press(4'h5);
    chk("t5_relock", 32'(bus.unlocked), 32'd0);
    chk("t5_key_dropped", 32'(bus.digit_count), 32'd0);
    idle(5);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
